// File: rtl/cc_digit_scanner.sv
// Common-cathode digit scanner: time-multiplexes a frame-buffered word across NUM_DIGITS
// digits with a prescaled dwell and an all-off gap between digits to avoid ghosting.
module cc_digit_scanner #(
    parameter int DATAWIDTH_DECODER_SELECTION = 2,
    parameter int DATAWIDTH_DIGIT             = 4,
    parameter int NUM_DIGITS                  = 2,
    parameter int PRESCALER_MAX               = 49999,
    parameter int DWELL_TICKS                 = 4
) (
    input  logic                                    CC_DIGIT_SCANNER_CLOCK_50,
    input  logic                                    CC_DIGIT_SCANNER_RESET_InHigh,
    input  logic                                    CC_DIGIT_SCANNER_enable_InHigh,
    input  logic                                    CC_DIGIT_SCANNER_blank_InHigh,
    input  logic                                    CC_DIGIT_SCANNER_load_InHigh,
    input  logic [NUM_DIGITS*DATAWIDTH_DIGIT-1:0]   CC_DIGIT_SCANNER_data_InBUS,
    output logic [DATAWIDTH_DECODER_SELECTION-1:0]  CC_DIGIT_SCANNER_selection_OutBUS,
    output logic [DATAWIDTH_DIGIT-1:0]              CC_DIGIT_SCANNER_digit_OutBUS,
    output logic                                    CC_DIGIT_SCANNER_tick_OutHigh,
    output logic                                    CC_DIGIT_SCANNER_frame_OutHigh
);

    localparam int SW = DATAWIDTH_DECODER_SELECTION;
    localparam int BW = NUM_DIGITS * DATAWIDTH_DIGIT;
    localparam int PW = $clog2(PRESCALER_MAX + 2);
    localparam int DW = $clog2(DWELL_TICKS + 1);

    localparam logic [SW-1:0] SEL_OFF    = '1;
    localparam logic [SW-1:0] INDEX_LAST = SW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] PRE_LAST   = PW'(PRESCALER_MAX);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    state_t          state;
    logic [PW-1:0]   prescaler;
    logic [DW-1:0]   dwell;
    logic [SW-1:0]   index;
    logic [BW-1:0]   shadow;
    logic            load_pending;

    logic            enable;
    logic            wrap;
    logic            frame_event;
    logic            capture;
    logic [SW-1:0]   index_next;
    logic [BW-1:0]   shadow_next;

    function automatic logic [DATAWIDTH_DIGIT-1:0] nibble_at(input logic [BW-1:0] word,
                                                             input logic [SW-1:0] idx);
        return word[DATAWIDTH_DIGIT*idx +: DATAWIDTH_DIGIT];
    endfunction

    assign enable      = CC_DIGIT_SCANNER_enable_InHigh;
    assign wrap        = enable && (state != IDLE) && (prescaler == PRE_LAST);
    assign frame_event = wrap && (state == GAP) && (index == INDEX_LAST);
    assign index_next  = (index == INDEX_LAST) ? '0 : index + 1'b1;

    // The shadow only changes between frames, or immediately while the scanner is idle.
    assign capture     = enable ? (frame_event && (load_pending || CC_DIGIT_SCANNER_load_InHigh))
                                : CC_DIGIT_SCANNER_load_InHigh;
    assign shadow_next = capture ? CC_DIGIT_SCANNER_data_InBUS : shadow;

    always_ff @(posedge CC_DIGIT_SCANNER_CLOCK_50 or posedge CC_DIGIT_SCANNER_RESET_InHigh) begin
        if (CC_DIGIT_SCANNER_RESET_InHigh) begin
            state                             <= IDLE;
            prescaler                         <= '0;
            dwell                             <= '0;
            index                             <= '0;
            shadow                            <= '0;
            load_pending                      <= 1'b0;
            CC_DIGIT_SCANNER_selection_OutBUS <= SEL_OFF;
            CC_DIGIT_SCANNER_digit_OutBUS     <= '0;
            CC_DIGIT_SCANNER_tick_OutHigh     <= 1'b0;
            CC_DIGIT_SCANNER_frame_OutHigh    <= 1'b0;
        end else begin
            CC_DIGIT_SCANNER_tick_OutHigh  <= wrap;
            CC_DIGIT_SCANNER_frame_OutHigh <= frame_event;
            shadow                         <= shadow_next;
            if (capture)
                load_pending <= 1'b0;
            else if (CC_DIGIT_SCANNER_load_InHigh)
                load_pending <= 1'b1;

            if (!enable) begin
                state                             <= IDLE;
                prescaler                         <= '0;
                dwell                             <= '0;
                index                             <= '0;
                CC_DIGIT_SCANNER_selection_OutBUS <= SEL_OFF;
                CC_DIGIT_SCANNER_digit_OutBUS     <= '0;
            end else begin
                prescaler                         <= wrap ? '0 : prescaler + 1'b1;
                CC_DIGIT_SCANNER_selection_OutBUS <= index;
                CC_DIGIT_SCANNER_digit_OutBUS     <= nibble_at(shadow_next, index);
                case (state)
                    // The prescaler is held at zero so the first digit gets a full dwell.
                    IDLE: begin
                        state                             <= SHOW;
                        prescaler                         <= '0;
                        dwell                             <= '0;
                        index                             <= '0;
                        CC_DIGIT_SCANNER_selection_OutBUS <= '0;
                        CC_DIGIT_SCANNER_digit_OutBUS     <= nibble_at(shadow_next, '0);
                    end
                    SHOW: begin
                        if (wrap) begin
                            if (dwell == DWELL_LAST) begin
                                state                             <= GAP;
                                dwell                             <= '0;
                                CC_DIGIT_SCANNER_selection_OutBUS <= SEL_OFF;
                                CC_DIGIT_SCANNER_digit_OutBUS     <= '0;
                            end else begin
                                dwell <= dwell + 1'b1;
                            end
                        end
                    end
                    GAP: begin
                        if (wrap) begin
                            state                             <= SHOW;
                            index                             <= index_next;
                            CC_DIGIT_SCANNER_selection_OutBUS <= index_next;
                            CC_DIGIT_SCANNER_digit_OutBUS     <= nibble_at(shadow_next, index_next);
                        end else begin
                            CC_DIGIT_SCANNER_selection_OutBUS <= SEL_OFF;
                            CC_DIGIT_SCANNER_digit_OutBUS     <= '0;
                        end
                    end
                    default: begin
                        state                             <= IDLE;
                        CC_DIGIT_SCANNER_selection_OutBUS <= SEL_OFF;
                        CC_DIGIT_SCANNER_digit_OutBUS     <= '0;
                    end
                endcase
            end

            if (CC_DIGIT_SCANNER_blank_InHigh) begin
                CC_DIGIT_SCANNER_selection_OutBUS <= SEL_OFF;
                CC_DIGIT_SCANNER_digit_OutBUS     <= '0;
            end
        end
    end

endmodule
